axi4_wr_slave_mem: RTL and testbench
====================================

AXI4_WR_SLAVE_MEM -- requirements
Module: axi4_wr_slave_mem

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4, meaning AWID/BID width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning W data width, power of 2, 8..1024.
REQ-004 The block SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, meaning byte-strobe width.
REQ-005 The block SHALL have parameter MEM_DEPTH, default 256, meaning storage words of DATA_WIDTH, power of 2.
REQ-006 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; the ports SHALL be as follows:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- s_axi_awid  input  ID_WIDTH  write ID
- s_axi_awaddr  input  ADDR_WIDTH  burst start byte address
- s_axi_awlen  input  8  beats minus 1
- s_axi_awsize  input  3  log2 bytes per beat
- s_axi_awburst  input  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_awvalid  input  1  AW valid
- s_axi_awready  output  1  AW ready
- s_axi_wdata  input  DATA_WIDTH  write data
- s_axi_wstrb  input  STRB_WIDTH  byte enables
- s_axi_wlast  input  1  last beat flag
- s_axi_wvalid  input  1  W valid
- s_axi_wready  output  1  W ready
- s_axi_bid  output  ID_WIDTH  response ID, equals latched AWID
- s_axi_bresp  output  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  output  1  B valid
- s_axi_bready  input  1  B ready
- rd_addr  input  log2(MEM_DEPTH)  backdoor word index
- rd_data  output  DATA_WIDTH  combinational mem[rd_addr]

Function
REQ-007 The FSM SHALL have states IDLE, DATA and RESP.
- IDLE: awready=1.
- DATA: wready=1.
- RESP: bvalid=1.
- All other handshake outputs are 0 in each state.
REQ-008 On awvalid&&awready in IDLE, the block SHALL latch id, addr, len, size and burst, clear the beat counter, and enter DATA on the next cycle.
REQ-009 On each wvalid&&wready, the block SHALL write every byte lane i with wstrb[i]=1 into mem[(addr/STRB_WIDTH) mod MEM_DEPTH]; lanes with wstrb[i]=0 keep their value.
REQ-010 Next beat address SHALL be computed as follows:
- FIXED: unchanged.
- INCR: addr + 2^size.
- WRAP: addr + 2^size, wrapped within the aligned (len+1)*2^size region.
- Burst 11: treated as FIXED.
REQ-011 An awsize greater than log2(STRB_WIDTH) SHALL be clamped to log2(STRB_WIDTH).
REQ-012 The burst SHALL end on beat count == len; wlast SHALL NOT end the burst early. The FSM SHALL then enter RESP the cycle after the final W handshake.
REQ-013 In RESP, bid and bresp SHALL be held stable until bready; on bvalid&&bready the FSM SHALL return to IDLE, with awready=1 the next cycle.
REQ-014 Throughput SHALL be one W beat per cycle; the minimum burst of len=0 SHALL complete as AW, W, B on three consecutive cycles with bready=1.
REQ-015 W beats arriving while in IDLE SHALL NOT be accepted (wready=0) and SHALL NOT write memory.
REQ-016 rd_data SHALL reflect writes on the cycle after the write edge.

Reset
REQ-017 With rst=1 at a clk edge, the block SHALL:
- enter IDLE;
- set awready=1, wready=0, bvalid=0, bid=0, bresp=00;
- clear the beat counter.
REQ-018 Reset mid-burst SHALL abandon the burst with no B response; memory contents are not reset and retain bytes already written.

Configuration
REQ-019 The feature SHALL be controlled by macro AXI_WR_SLV_ERR_EN.
- Defined: bresp=10 if any beat address is >= MEM_DEPTH*STRB_WIDTH (that beat is not written), or if wlast mismatches the final-beat position.
- Undefined: bresp is always 00 and addresses wrap modulo MEM_DEPTH.

Verification
REQ-020 INCR burst: awaddr=0x10, awlen=3, awsize=2, data 0xA0..0xA3, strb=F -> mem[4..7]=0xA0..0xA3; bresp=00; bid=awid.
REQ-021 WRAP burst: awaddr=0x38, awlen=3, awsize=2 -> beats written to words 14,15,12,13.
REQ-022 Strobe: mem[0]=0xFFFFFFFF, then FIXED len=1 to addr 0 with strb=0001 then 0100, data 0x11223344 -> mem[0]=0xFF22FF44.
REQ-023 Backpressure: bready held 0 for 5 cycles -> bvalid, bid and bresp stable; awready=0 until the cycle after the B handshake.
REQ-024 With AXI_WR_SLV_ERR_EN defined: awaddr=0x400 (out of range), len=0 -> bresp=10, memory unchanged. With it undefined: mem[0] written, bresp=00.
REQ-025 Reset asserted on beat 2 of a len=7 burst -> IDLE next cycle, bvalid=0, words 0..1 retain the written data.

Source files
------------

// File: rtl/axi4_wr_slave_mem.sv
// AXI4 write-only slave backed by a byte-strobed word memory with a combinational backdoor read port.
// Optional macro AXI_WR_SLV_ERR_EN: SLVERR on out-of-range beats or wlast misplacement.
module axi4_wr_slave_mem #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]        s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [ID_WIDTH-1:0]          s_axi_bid,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  localparam int unsigned LSB_W    = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0]  MAX_SIZE = 3'(LSB_W);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    awready_d, wready_d, bvalid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt_c, incr_c, wrap_mask_c;
  logic [7:0]              len_q, beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q, beat_err_c, wr_en_c;
  logic                    aw_hs, w_hs, b_hs, last_beat;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign b_hs      = s_axi_bvalid && s_axi_bready;
  assign last_beat = (beat_q == len_q);

`ifdef AXI_WR_SLV_ERR_EN
  logic oob_c;
  assign oob_c      = (addr_q >> (LSB_W + IDX_W)) != '0;
  assign beat_err_c = oob_c || (s_axi_wlast != last_beat);
  assign wr_en_c    = w_hs && !oob_c;
`else
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;
  assign beat_err_c   = 1'b0;
  assign wr_en_c      = w_hs;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake-ready decode of the next state
  always_comb begin
    state_d   = state_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = 1'b0;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (state_d)
      IDLE:    awready_d = 1'b1;
      DATA:    wready_d  = 1'b1;
      RESP:    bvalid_d  = 1'b1;
      default: awready_d = 1'b0;
    endcase
  end

  // Next beat address; WRAP keeps the upper bits of the aligned burst region
  always_comb begin
    incr_c      = ADDR_WIDTH'(1) << size_q;
    wrap_mask_c = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b01:   addr_nxt_c = addr_q + incr_c;
      2'b10:   addr_nxt_c = (addr_q & ~wrap_mask_c) | ((addr_q + incr_c) & wrap_mask_c);
      default: addr_nxt_c = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'b00;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      beat_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        addr_q    <= s_axi_awaddr;
        len_q     <= s_axi_awlen;
        size_q    <= (s_axi_awsize > MAX_SIZE) ? MAX_SIZE : s_axi_awsize;
        burst_q   <= s_axi_awburst;
        beat_q    <= '0;
        err_q     <= 1'b0;
      end
      if (w_hs) begin
        addr_q <= addr_nxt_c;
        beat_q <= beat_q + 8'd1;
        err_q  <= err_q | beat_err_c;
        if (last_beat) s_axi_bresp <= (err_q | beat_err_c) ? 2'b10 : 2'b00;
      end
    end
  end

  // Storage is never reset; a burst cut by reset keeps the beats already written
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[addr_q[LSB_W +: IDX_W]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_axi4_wr_slave_mem.sv
// Directed and randomized bench for axi4_wr_slave_mem against a byte-level memory model.
module tb_axi4_wr_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mmem [256];
  logic [3:0]  mval [256];
  logic [31:0] dq [16];
  logic [3:0]  sq [16];
  int          touched [$];

  axi4_wr_slave_mem dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] v);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = v[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Compares only bytes the model knows were written
  task automatic chk_word(input string tag, input int w);
    logic [31:0] m;
    rd_addr = 8'(w);
    #1;
    m = lane_mask(mval[w]);
    chk(tag, rd_data & m, mmem[w] & m);
  endtask

  task automatic chk_touched(input string tag);
    foreach (touched[i]) chk_word(tag, touched[i]);
    tick();
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    w = int'((a / 4) % 256);
    for (int i = 0; i < 4; i++)
      if (s[i]) begin
        mmem[w][8*i +: 8] = d[8*i +: 8];
        mval[w][i] = 1'b1;
      end
    touched.push_back(w);
  endtask

  // One complete transaction; expected addresses come from the burst rules directly
  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                       input int size, input logic [1:0] btype, input int bwait,
                       input bit early_last, input bit gaps);
    int          bytes, total;
    logic [31:0] base, a;
    bit          err, wl;
    bytes = 1 << ((size > 2) ? 2 : size);
    total = (len + 1) * bytes;
    base  = (addr / total) * total;
    err   = 1'b0;
    touched.delete();
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = btype; s_axi_awvalid = 1'b1;
    chk("awready_idle", 32'(s_axi_awready), 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        chk("wready_stall", 32'(s_axi_wready), 32'd1);
        tick();
      end
      chk("wready_data", 32'(s_axi_wready), 32'd1);
      chk("awready_data", 32'(s_axi_awready), 32'd0);
      chk("bvalid_data", 32'(s_axi_bvalid), 32'd0);
      case (btype)
        2'b01:   a = addr + 32'(k * bytes);
        2'b10:   a = base + ((addr - base + 32'(k * bytes)) % 32'(total));
        default: a = addr;
      endcase
      wl = early_last ? (k == 0) : (k == len);
      if (wl != (k == len)) err = 1'b1;
      s_axi_wdata = dq[k]; s_axi_wstrb = sq[k]; s_axi_wlast = wl; s_axi_wvalid = 1'b1;
      tick();
`ifdef AXI_WR_SLV_ERR_EN
      if (a >= 32'd1024) err = 1'b1;
      else model_write(a, dq[k], sq[k]);
`else
      model_write(a, dq[k], sq[k]);
`endif
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
`ifndef AXI_WR_SLV_ERR_EN
    err = 1'b0;
`endif
    for (int w = 0; w <= bwait; w++) begin
      chk("bvalid_resp", 32'(s_axi_bvalid), 32'd1);
      chk("bid_resp", 32'(s_axi_bid), 32'(id));
      chk("bresp_resp", 32'(s_axi_bresp), err ? 32'd2 : 32'd0);
      chk("awready_resp", 32'(s_axi_awready), 32'd0);
      s_axi_bready = (w == bwait);
      tick();
    end
    s_axi_bready = 1'b0;
    chk("bvalid_after", 32'(s_axi_bvalid), 32'd0);
    chk("awready_after", 32'(s_axi_awready), 32'd1);
    chk_touched("mem_burst");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mmem[i] = '0; mval[i] = '0; end
    rst = 1'b1; s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_awready", 32'(s_axi_awready), 32'd1);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_bid", 32'(s_axi_bid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);

    // INCR, 4 beats to words 4..7
    for (int k = 0; k < 4; k++) begin dq[k] = 32'hA0 + 32'(k); sq[k] = 4'hF; end
    burst(4'h5, 32'h10, 3, 2, 2'b01, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rd_addr = 8'(4 + k); #1;
      chk("incr_word", rd_data, 32'hA0 + 32'(k));
    end
    tick();

    // WRAP from 0x38 lands on words 14,15,12,13
    for (int k = 0; k < 4; k++) begin dq[k] = 32'hB0 + 32'(k); sq[k] = 4'hF; end
    burst(4'h9, 32'h38, 3, 2, 2'b10, 0, 1'b0, 1'b0);
    rd_addr = 8'd14; #1; chk("wrap_w14", rd_data, 32'hB0);
    rd_addr = 8'd15; #1; chk("wrap_w15", rd_data, 32'hB1);
    rd_addr = 8'd12; #1; chk("wrap_w12", rd_data, 32'hB2);
    rd_addr = 8'd13; #1; chk("wrap_w13", rd_data, 32'hB3);
    tick();

    // Byte strobes merge into a pre-filled word
    dq[0] = 32'hFFFF_FFFF; sq[0] = 4'hF;
    burst(4'h1, 32'h0, 0, 2, 2'b01, 0, 1'b0, 1'b0);
    dq[0] = 32'h1122_3344; sq[0] = 4'b0001;
    dq[1] = 32'h1122_3344; sq[1] = 4'b0100;
    burst(4'h2, 32'h0, 1, 2, 2'b00, 0, 1'b0, 1'b0);
    rd_addr = 8'd0; #1; chk("strb_word0", rd_data, 32'hFF22_FF44);
    tick();

    // B backpressure for 5 cycles; oversize awsize is clamped to 4 bytes
    dq[0] = 32'hC0C0_C0C0; sq[0] = 4'hF; dq[1] = 32'hC1C1_C1C1; sq[1] = 4'hF;
    burst(4'hE, 32'h80, 1, 5, 2'b01, 5, 1'b0, 1'b0);

    // Address beyond the memory
    dq[0] = 32'hDEAD_BEEF; sq[0] = 4'hF;
    burst(4'h3, 32'h400, 0, 2, 2'b01, 1, 1'b0, 1'b0);
    rd_addr = 8'd0; #1;
`ifdef AXI_WR_SLV_ERR_EN
    chk("oob_word0", rd_data, 32'hFF22_FF44);
`else
    chk("oob_word0", rd_data, 32'hDEAD_BEEF);
`endif
    tick();

`ifdef AXI_WR_SLV_ERR_EN
    dq[0] = 32'h1; dq[1] = 32'h2; sq[0] = 4'hF; sq[1] = 4'hF;
    burst(4'h4, 32'h200, 1, 2, 2'b01, 0, 1'b1, 1'b0);
`endif

    // W in IDLE must be refused and must not write
    touched.delete();
    touched.push_back(0);
    s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    chk("wready_idle", 32'(s_axi_wready), 32'd0);
    tick();
    chk("wready_idle2", 32'(s_axi_wready), 32'd0);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk_touched("idle_w_nowrite");

    // Random bursts
    for (int t = 0; t < 30; t++) begin
      int bt, sz, bytes, len;
      logic [31:0] addr;
      bt = $urandom_range(0, 3);
      sz = $urandom_range(0, 3);
      bytes = 1 << ((sz > 2) ? 2 : sz);
      if (bt == 2) begin
        len  = (1 << $urandom_range(1, 4)) - 1;
        addr = 32'($urandom_range(0, 1023)) & ~32'(bytes - 1);
      end else begin
        len  = $urandom_range(0, 15);
        addr = 32'($urandom_range(0, 1024 - (len + 1) * bytes)) & ~32'(bytes - 1);
      end
      for (int k = 0; k < 16; k++) begin dq[k] = $urandom; sq[k] = 4'($urandom); end
      burst(4'($urandom), addr, len, sz, 2'(bt), $urandom_range(0, 3), 1'b0, 1'b1);
    end

    // Reset on beat 2 of an 8-beat burst
    s_axi_awid = 4'h7; s_axi_awaddr = 32'h0; s_axi_awlen = 8'd7; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    touched.delete();
    for (int k = 0; k < 2; k++) begin
      s_axi_wdata = 32'h7700_0000 + 32'(k); s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      model_write(32'(4 * k), 32'h7700_0000 + 32'(k), 4'hF);
    end
    s_axi_wvalid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_awready", 32'(s_axi_awready), 32'd1);
    chk("mid_rst_wready", 32'(s_axi_wready), 32'd0);
    chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("mid_rst_bid", 32'(s_axi_bid), 32'd0);
    tick();
    chk("mid_rst_bvalid2", 32'(s_axi_bvalid), 32'd0);
    chk_touched("mid_rst_keep");

    // Final sweep of every written word
    touched.delete();
    for (int i = 0; i < 256; i++) if (mval[i] != 4'h0) touched.push_back(i);
    chk_touched("final_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
